// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i memory arbiter.
// Port ids, arbiter FSM states and a saturating age helper.
package rv32i_pkg;

  localparam logic [1:0] PORT_IF = 2'd0;
  localparam logic [1:0] PORT_DM = 2'd1;
  localparam logic [1:0] PORT_EX = 2'd2;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rv32i_arb_retpipe.sv
// Read-return delay line: tags each issued read with its port
// so the RAM data arriving LATENCY cycles later can be routed.
module rv32i_arb_retpipe #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  input  logic [1:0] push_port,
  output logic       out_valid,
  output logic [1:0] out_port
);

  logic [LATENCY-1:0]   vld_q, vld_d;
  logic [2*LATENCY-1:0] prt_q, prt_d;

  always_comb begin
    vld_d = (vld_q << 1) | LATENCY'(push_valid);
    prt_d = (prt_q << 2) | (2*LATENCY)'(push_port);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      prt_q <= '0;
    end else begin
      vld_q <= vld_d;
      prt_q <= prt_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_port  = prt_q[2*LATENCY-1 -: 2];

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Three-way single-port RAM arbiter: DM > IF > EX with aging,
// EX burst ownership and a tagged read-return pipeline.
module rv32i_mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wmask,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  input  logic        ex_req,
  input  logic        ex_we,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_wmask,
  output logic        ex_gnt,
  output logic        ex_rvalid,
  input  logic        ex_lock,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic [2:0]    req, cand, starved, gnt;
  logic [7:0]    age_q [3];
  logic [7:0]    age_d [3];
  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          blk_q, blk_d;
  logic          old_v;
  logic [1:0]    old_p;
  logic          push_v;
  logic [1:0]    push_p;
  logic          ret_v;
  logic [1:0]    ret_p;

  assign req = {ex_req, dm_req, if_req};

  // Starved ports beat the default order; the oldest wins, ties EX > IF > DM.
  always_comb begin
    cand = {ex_req & ~blk_q, dm_req, if_req};
    for (int p = 0; p < 3; p++)
      starved[p] = cand[p] && (age_q[p] >= 8'(STARVE_LIMIT));
    old_v = starved[PORT_EX];
    old_p = PORT_EX;
    if (starved[PORT_IF] &&
        (!old_v || age_q[PORT_IF] > age_q[old_p])) begin
      old_v = 1'b1;
      old_p = PORT_IF;
    end
    if (starved[PORT_DM] &&
        (!old_v || age_q[PORT_DM] > age_q[old_p])) begin
      old_v = 1'b1;
      old_p = PORT_DM;
    end
    gnt = '0;
    if (rst)
      gnt = '0;
    else if (state_q == BURST && ex_req)
      gnt[PORT_EX] = 1'b1;
    else if (old_v)
      gnt[old_p] = 1'b1;
    else if (cand[PORT_DM])
      gnt[PORT_DM] = 1'b1;
    else if (cand[PORT_IF])
      gnt[PORT_IF] = 1'b1;
    else if (cand[PORT_EX])
      gnt[PORT_EX] = 1'b1;
  end

  always_comb begin
    mem_en    = |gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    push_p    = PORT_IF;
    if (gnt[PORT_IF]) begin
      mem_addr = if_addr;
    end else if (gnt[PORT_DM]) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_wmask = dm_wmask;
      push_p    = PORT_DM;
    end else if (gnt[PORT_EX]) begin
      mem_we    = ex_we;
      mem_addr  = ex_addr;
      mem_wdata = ex_wdata;
      mem_wmask = ex_wmask;
      push_p    = PORT_EX;
    end
    push_v = mem_en & ~mem_we;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = 1'b0;
    for (int p = 0; p < 3; p++)
      age_d[p] = (req[p] && !gnt[p]) ? sat_inc8(age_q[p]) : 8'd0;
    unique case (state_q)
      ARB: begin
        if (gnt[PORT_EX] && ex_lock) begin
          if (MAX_BURST > 1) begin
            state_d = BURST;
            cnt_d   = CW'(1);
          end else begin
            blk_d = 1'b1;
          end
        end
      end
      BURST: begin
        if (gnt[PORT_EX])
          cnt_d = cnt_q + CW'(1);
        if (!ex_lock) begin
          state_d = ARB;
          cnt_d   = '0;
        end else if (cnt_d == CW'(MAX_BURST)) begin
          // Hold EX off one cycle so DM and IF can drain.
          state_d = ARB;
          cnt_d   = '0;
          blk_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      cnt_q   <= '0;
      blk_q   <= 1'b0;
      for (int p = 0; p < 3; p++)
        age_q[p] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      for (int p = 0; p < 3; p++)
        age_q[p] <= age_d[p];
    end
  end

  rv32i_arb_retpipe #(
    .LATENCY(RAM_LATENCY)
  ) u_retpipe (
    .clk       (clk),
    .rst       (rst),
    .push_valid(push_v),
    .push_port (push_p),
    .out_valid (ret_v),
    .out_port  (ret_p)
  );

  assign if_gnt    = gnt[PORT_IF];
  assign dm_gnt    = gnt[PORT_DM];
  assign ex_gnt    = gnt[PORT_EX];
  assign if_rvalid = ret_v & ~rst & (ret_p == PORT_IF);
  assign dm_rvalid = ret_v & ~rst & (ret_p == PORT_DM);
  assign ex_rvalid = ret_v & ~rst & (ret_p == PORT_EX);
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: directed scenarios plus random
// traffic checked against a rule-level arbitration model.
module tb_rv32i_mem_arbiter;
  import rv32i_pkg::*;

  localparam int LAT  = 4;
  localparam int LIM  = 8;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, ex_req, dm_we, ex_we, ex_lock;
  logic [31:0] if_addr, dm_addr, ex_addr, dm_wdata, ex_wdata;
  logic [3:0]  dm_wmask, ex_wmask;
  logic        if_gnt, dm_gnt, ex_gnt;
  logic        if_rvalid, dm_rvalid, ex_rvalid;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wmask;

  rv32i_mem_arbiter #(
    .RAM_LATENCY (LAT),
    .STARVE_LIMIT(LIM),
    .MAX_BURST   (MAXB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_wmask (dm_wmask),
    .dm_gnt   (dm_gnt),
    .dm_rvalid(dm_rvalid),
    .ex_req   (ex_req),
    .ex_we    (ex_we),
    .ex_addr  (ex_addr),
    .ex_wdata (ex_wdata),
    .ex_wmask (ex_wmask),
    .ex_gnt   (ex_gnt),
    .ex_rvalid(ex_rvalid),
    .ex_lock  (ex_lock),
    .rdata    (rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wmerge(input logic [31:0] o,
                                         input logic [31:0] w,
                                         input logic [3:0]  m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  // RAM behind the DUT
  logic [31:0] eram [512] = '{default: 32'h0};
  logic [31:0] rpipe [LAT];
  assign mem_rdata = rpipe[LAT-1];

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--)
      rpipe[i] <= rpipe[i-1];
    rpipe[0] <= (mem_en && !mem_we) ? eram[mem_addr[8:0]] : 32'h5a5a_0000;
    if (mem_en && mem_we)
      eram[mem_addr[8:0]] <= wmerge(eram[mem_addr[8:0]], mem_wdata, mem_wmask);
  end

  // Reference model
  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } ret_t;

  logic [31:0] rram [512] = '{default: 32'h0};
  ret_t        retq [$];
  int          m_age [3];
  bit          m_burst, m_blk;
  int          m_cnt;
  int          cyc, n_chk, n_err, last_g;
  logic        obs_if, obs_dm, obs_ex, obs_en, obs_we;
  logic        obs_ifrv, obs_dmrv, obs_exrv;
  logic [3:0]  obs_wmask;
  logic [31:0] obs_rdata;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_grant();
    bit c [3];
    int best;
    int ord_s [3] = '{2, 0, 1};
    int ord_d [3] = '{1, 0, 2};
    if (rst) return -1;
    if (m_burst && ex_req) return 2;
    c[0] = if_req;
    c[1] = dm_req;
    c[2] = ex_req && !m_blk;
    best = -1;
    foreach (ord_s[i]) begin
      int p = ord_s[i];
      if (c[p] && m_age[p] >= LIM && (best < 0 || m_age[p] > m_age[best]))
        best = p;
    end
    if (best >= 0) return best;
    foreach (ord_d[i])
      if (c[ord_d[i]]) return ord_d[i];
    return -1;
  endfunction

  function automatic logic [31:0] g_addr(input int g);
    return g == 0 ? if_addr : (g == 1 ? dm_addr : ex_addr);
  endfunction

  function automatic logic g_we(input int g);
    return g == 1 ? dm_we : (g == 2 ? ex_we : 1'b0);
  endfunction

  function automatic logic [31:0] g_wd(input int g);
    return g == 1 ? dm_wdata : ex_wdata;
  endfunction

  function automatic logic [3:0] g_wm(input int g);
    return g == 1 ? dm_wmask : ex_wmask;
  endfunction

  task automatic step();
    int   g;
    bit   ev;
    bit   rq [3];
    ret_t r;
    logic [8:0] a;
    #1;
    g = exp_grant();
    obs_if = if_gnt; obs_dm = dm_gnt; obs_ex = ex_gnt;
    obs_en = mem_en; obs_we = mem_we; obs_wmask = mem_wmask;
    obs_ifrv = if_rvalid; obs_dmrv = dm_rvalid; obs_exrv = ex_rvalid;
    obs_rdata = rdata;
    chk("if_gnt", if_gnt, g == 0);
    chk("dm_gnt", dm_gnt, g == 1);
    chk("ex_gnt", ex_gnt, g == 2);
    chk("mem_en", mem_en, g >= 0);
    if (g >= 0) begin
      chk("mem_addr", mem_addr, g_addr(g));
      chk("mem_we", mem_we, g_we(g));
      if (g_we(g)) begin
        chk("mem_wdata", mem_wdata, g_wd(g));
        chk("mem_wmask", mem_wmask, g_wm(g));
      end else if (g == 0) begin
        chk("mem_wmask_if", mem_wmask, 4'd0);
      end
    end
    ev = !rst && retq.size() > 0 && retq[0].due == cyc;
    chk("if_rvalid", if_rvalid, ev && retq[0].port == 0);
    chk("dm_rvalid", dm_rvalid, ev && retq[0].port == 1);
    chk("ex_rvalid", ex_rvalid, ev && retq[0].port == 2);
    if (ev) chk("rdata", rdata, retq[0].data);
    last_g = g;
    @(posedge clk);
    if (rst) begin
      retq.delete();
      foreach (m_age[p]) m_age[p] = 0;
      m_burst = 0; m_blk = 0; m_cnt = 0;
    end else begin
      if (ev) void'(retq.pop_front());
      if (g >= 0) begin
        a = g_addr(g);
        if (g_we(g)) begin
          rram[a] = wmerge(rram[a], g_wd(g), g_wm(g));
        end else begin
          r.due = cyc + LAT; r.port = g; r.data = rram[a];
          retq.push_back(r);
        end
      end
      rq[0] = if_req; rq[1] = dm_req; rq[2] = ex_req;
      foreach (m_age[p])
        m_age[p] = (rq[p] && g != p) ? (m_age[p] < 255 ? m_age[p] + 1 : 255) : 0;
      if (!m_burst) begin
        m_blk = 0;
        if (g == 2 && ex_lock) begin m_burst = 1; m_cnt = 1; end
      end else begin
        m_blk = 0;
        if (g == 2) m_cnt++;
        if (!ex_lock) begin
          m_burst = 0; m_cnt = 0;
        end else if (m_cnt == MAXB) begin
          m_burst = 0; m_cnt = 0; m_blk = 1;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    if_req = 0; dm_req = 0; ex_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n, wt, f, run, t_dm, t_if;
    bit ge [40];
    bit gd [40];
    bit pend [3];
    rst = 1; ex_lock = 0;
    if_req = 1; dm_req = 1; ex_req = 1;
    dm_we = 0; ex_we = 0;
    if_addr = 0; dm_addr = 0; ex_addr = 0;
    dm_wdata = 0; ex_wdata = 0; dm_wmask = 0; ex_wmask = 0;
    @(negedge clk);
    step();
    chk("rst_outputs", {obs_if, obs_dm, obs_ex, obs_en}, 4'd0);
    step();
    rst = 0;
    idle(2);

    // idle with ex_lock: nothing granted, FSM stays ARB
    ex_lock = 1; n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n += int'(obs_if | obs_dm | obs_ex | obs_en);
    end
    chk("t6_no_grants", n, 0);
    ex_lock = 0; ex_req = 1; dm_req = 1;
    step();
    chk("t6_arb_state", obs_dm, 1'b1);
    idle(LAT + 2);

    // masked write then read-back
    dm_req = 1; dm_we = 1; dm_addr = 32'h100;
    dm_wdata = 32'hDEADBEEF; dm_wmask = 4'b0011;
    step();
    chk("t4_mem_we", obs_we, 1'b1);
    chk("t4_wmask", obs_wmask, 4'b0011);
    dm_we = 0;
    step();
    dm_req = 0; n = 0; wt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_dmrv) begin
        n++;
        chk("t4_rdata", obs_rdata, 32'h0000BEEF);
      end
    end
    chk("t4_rvalid_count", n, 1);

    // DM beats IF from idle; returns in grant order
    t_dm = -100; t_if = -100;
    for (int i = 0; i < LAT + 4; i++) begin
      if_req = (i < 2); dm_req = (i == 0);
      if_addr = 32'h100; dm_addr = 32'h100;
      step();
      if (i == 0) begin
        chk("t1_dm_first", obs_dm, 1'b1);
        chk("t1_if_wait", obs_if, 1'b0);
      end
      if (i == 1) chk("t1_if_next", obs_if, 1'b1);
      if (obs_dmrv) t_dm = i;
      if (obs_ifrv) t_if = i;
    end
    chk("t1_dm_latency", t_dm, LAT);
    chk("t1_rv_order", t_if - t_dm, 1);
    idle(2);

    // EX starving behind continuous DM
    dm_req = 1; dm_we = 1; ex_req = 1; ex_we = 1; ex_lock = 0;
    wt = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_ex && wt < 0) wt = i;
    end
    chk("t2_ex_wait", wt, LIM);
    idle(3);

    // EX burst with lock, DM requesting throughout
    dm_req = 1; dm_we = 1; ex_req = 1; ex_we = 1; ex_lock = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      ge[i] = obs_ex; gd[i] = obs_dm;
    end
    f = -1;
    for (int i = 39; i >= 0; i--) if (ge[i]) f = i;
    run = 0;
    if (f >= 0)
      while (f + run < 40 && ge[f+run]) run++;
    chk("t3_burst_len", run, MAXB);
    if (f >= 0 && f + run < 40) begin
      chk("t3_gap_ex", ge[f+run], 1'b0);
      chk("t3_gap_dm", gd[f+run], 1'b1);
    end else begin
      chk("t3_gap_found", 0, 1);
    end
    ex_lock = 0; dm_we = 0; ex_we = 0;
    idle(3);

    // reset with three reads in flight
    dm_req = 1; dm_we = 0;
    for (int i = 1; i <= 3; i++) begin
      dm_addr = i;
      step();
    end
    dm_req = 0;
    step();
    rst = 1; n = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      n += int'(obs_ifrv | obs_dmrv | obs_exrv);
    end
    rst = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      n += int'(obs_ifrv | obs_dmrv | obs_exrv);
    end
    chk("t5_no_rvalid", n, 0);
    if_req = 1; dm_req = 1;
    step();
    chk("t5_dm_first", obs_dm, 1'b1);
    idle(LAT + 1);

    // random traffic
    foreach (pend[p]) pend[p] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend[0] && $urandom_range(0, 9) < 4) begin
        pend[0] = 1; if_addr = $urandom_range(0, 15);
      end
      if (!pend[1] && $urandom_range(0, 9) < 4) begin
        pend[1] = 1; dm_addr = $urandom_range(0, 15);
        dm_we = $urandom_range(0, 1); dm_wdata = $urandom;
        dm_wmask = 4'($urandom);
      end
      if (!pend[2] && $urandom_range(0, 9) < 4) begin
        pend[2] = 1; ex_addr = $urandom_range(0, 15);
        ex_we = $urandom_range(0, 1); ex_wdata = $urandom;
        ex_wmask = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) ex_lock = $urandom_range(0, 1);
      rst = ($urandom_range(0, 299) == 0);
      if_req = pend[0]; dm_req = pend[1]; ex_req = pend[2];
      step();
      if (last_g >= 0) pend[last_g] = 0;
    end
    rst = 0;
    idle(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
